// File: rtl/adc_sample_sequencer.sv
// Paces single-slot conversions on one ADC channel and turns each result into a
// signed sample on a valid/ready stream, with overrun and error counters for debug.
`timescale 1ns/1ps
module adc_sample_sequencer #(
  parameter int SAMPLE_DIV     = 6250,
  parameter int CHANNEL        = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clock_clk,
  input  logic        reset_sink_reset,
  input  logic        enable,
  output logic        command_valid,
  output logic [4:0]  command_channel,
  output logic        command_startofpacket,
  output logic        command_endofpacket,
  input  logic        command_ready,
  input  logic        response_valid,
  input  logic [4:0]  response_channel,
  input  logic [11:0] response_data,
  input  logic        response_startofpacket,
  input  logic        response_endofpacket,
  output logic [11:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic [15:0] overrun_count,
  output logic [15:0] error_count,
  output logic        busy
);

  // Handshakes: a beat moves on any cycle where valid && ready; once valid is
  // raised, the payload is held stable until that cycle.

  localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]  CHAN     = 5'(CHANNEL);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP} state_t;

  state_t      state, state_n;
  logic [15:0] tick_cnt, tmo_cnt;
  logic        tick_pending;
  logic        tick, consume, drop;
  logic        accept, capture, timeout, xfer;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic        unused_sop_eop;

  assign unused_sop_eop = &{1'b0, response_startofpacket, response_endofpacket};

  assign tick    = enable && (tick_cnt == DIV_LAST);
  assign consume = (state == IDLE) && tick_pending;
  // A pending tick being consumed this cycle leaves room for a new one.
  assign drop    = tick && tick_pending && !consume;
  assign xfer    = sample_valid && sample_ready;

  assign err_inc = {1'b0, drop} + {1'b0, timeout};
  assign err_sum = {1'b0, error_count} + {15'd0, err_inc};

  assign command_channel       = CHAN;
  assign command_startofpacket = command_valid;
  assign command_endofpacket   = command_valid;
  assign busy                  = (state != IDLE);

  always_comb begin
    state_n       = state;
    command_valid = 1'b0;
    accept        = 1'b0;
    capture       = 1'b0;
    timeout       = 1'b0;
    case (state)
      IDLE: begin
        if (tick_pending) state_n = ISSUE;
      end
      ISSUE: begin
        command_valid = 1'b1;
        if (command_ready) begin
          accept  = 1'b1;
          state_n = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (response_valid && (response_channel == CHAN)) begin
          capture = 1'b1;
          state_n = IDLE;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_clk) begin
    if (reset_sink_reset) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      tick_pending  <= 1'b0;
      tmo_cnt       <= '0;
      sample_data   <= '0;
      sample_valid  <= 1'b0;
      overrun_count <= '0;
      error_count   <= '0;
    end else begin
      state <= state_n;

      if (!enable || tick) tick_cnt <= '0;
      else                 tick_cnt <= tick_cnt + 16'd1;

      if (!enable)      tick_pending <= 1'b0;
      else if (tick)    tick_pending <= 1'b1;
      else if (consume) tick_pending <= 1'b0;

      if (accept)                  tmo_cnt <= '0;
      else if (state == WAIT_RESP) tmo_cnt <= tmo_cnt + 16'd1;

      // Offset-binary to two's complement is just an MSB flip.
      if (capture) begin
        sample_data  <= {~response_data[11], response_data[10:0]};
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready && (overrun_count != 16'hFFFF))
          overrun_count <= overrun_count + 16'd1;
      end else if (xfer) begin
        sample_valid <= 1'b0;
      end

      error_count <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end
  end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: tick timing, command handshake,
// channel filter, timeout, overrun, dropped tick and reset mid-command.
`timescale 1ns/1ps
module tb_adc_sample_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        command_valid;
  logic [4:0]  command_channel;
  logic        command_sop, command_eop;
  logic        command_ready;
  logic        response_valid;
  logic [4:0]  response_channel;
  logic [11:0] response_data;
  logic [11:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic [15:0] overrun_count;
  logic [15:0] error_count;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int n;
  int extra;
  logic [11:0] exp_q[$];

  adc_sample_sequencer #(.SAMPLE_DIV(16), .CHANNEL(1), .TIMEOUT_CYCLES(8)) dut (
    .clock_clk              (clk),
    .reset_sink_reset       (rst),
    .enable                 (enable),
    .command_valid          (command_valid),
    .command_channel        (command_channel),
    .command_startofpacket  (command_sop),
    .command_endofpacket    (command_eop),
    .command_ready          (command_ready),
    .response_valid         (response_valid),
    .response_channel       (response_channel),
    .response_data          (response_data),
    .response_startofpacket (1'b0),
    .response_endofpacket   (1'b0),
    .sample_data            (sample_data),
    .sample_valid           (sample_valid),
    .sample_ready           (sample_ready),
    .overrun_count          (overrun_count),
    .error_count            (error_count),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input int max, output int cycles);
    cycles = 0;
    while (!command_valid && cycles < max) begin
      step();
      cycles++;
    end
    chk("cmd_seen", {31'd0, command_valid}, 32'd1);
  endtask

  task automatic drive_resp(input logic [4:0] ch, input logic [11:0] code);
    response_valid   = 1'b1;
    response_channel = ch;
    response_data    = code;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; command_ready = 1'b0; sample_ready = 1'b0;
    response_valid = 1'b0; response_channel = '0; response_data = '0;
    step(); step();
    chk("rst_cmd_valid", {31'd0, command_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_sample_data", {20'd0, sample_data}, 32'd0);
    chk("rst_overrun", {16'd0, overrun_count}, 32'd0);
    chk("rst_error", {16'd0, error_count}, 32'd0);

    // Single conversion
    rst = 1'b0; enable = 1'b1; command_ready = 1'b1;
    wait_cmd(40, n);
    chk("first_tick_latency", n, 32'd17);
    chk("cmd_channel", {27'd0, command_channel}, 32'd1);
    chk("cmd_sop", {31'd0, command_sop}, 32'd1);
    chk("cmd_eop", {31'd0, command_eop}, 32'd1);
    chk("issue_busy", {31'd0, busy}, 32'd1);
    step();
    chk("accept_cmd_drop", {31'd0, command_valid}, 32'd0);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    step(); step();
    drive_resp(5'd1, 12'hA00);
    exp_q.push_back(12'h200);
    chk("pre_resp_valid", {31'd0, sample_valid}, 32'd0);
    step();
    response_valid = 1'b0;
    chk("single_valid", {31'd0, sample_valid}, 32'd1);
    chk("single_data", {20'd0, sample_data}, {20'd0, exp_q.pop_front()});
    chk("single_idle", {31'd0, busy}, 32'd0);
    chk("single_overrun", {16'd0, overrun_count}, 32'd0);
    chk("single_error", {16'd0, error_count}, 32'd0);
    sample_ready = 1'b1; enable = 1'b0;
    step();
    chk("single_xfer_clear", {31'd0, sample_valid}, 32'd0);

    // Backpressured command
    command_ready = 1'b0; enable = 1'b1;
    wait_cmd(40, n);
    chk("bp_tick_latency", n, 32'd17);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_cmd_held", {31'd0, command_valid}, 32'd1);
      chk("bp_cmd_channel", {27'd0, command_channel}, 32'd1);
    end
    command_ready = 1'b1;
    step();
    chk("bp_accept", {31'd0, command_valid}, 32'd0);
    enable = 1'b0;
    drive_resp(5'd1, 12'h800);
    exp_q.push_back(12'h000);
    step();
    response_valid = 1'b0;
    chk("bp_sample_valid", {31'd0, sample_valid}, 32'd1);
    chk("bp_sample_data", {20'd0, sample_data}, {20'd0, exp_q.pop_front()});
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (command_valid) extra++;
    end
    chk("bp_one_command", extra, 32'd0);
    chk("bp_sample_taken", {31'd0, sample_valid}, 32'd0);

    // Channel filter and timeout
    enable = 1'b1;
    wait_cmd(40, n);
    step();
    enable = 1'b0;
    drive_resp(5'd3, 12'h123);
    repeat (7) step();
    chk("tmo_still_busy", {31'd0, busy}, 32'd1);
    chk("tmo_no_error_yet", {16'd0, error_count}, 32'd0);
    step();
    response_valid = 1'b0;
    chk("tmo_idle", {31'd0, busy}, 32'd0);
    chk("tmo_error", {16'd0, error_count}, 32'd1);
    chk("tmo_no_sample", {31'd0, sample_valid}, 32'd0);

    // Overrun
    sample_ready = 1'b0; enable = 1'b1;
    wait_cmd(40, n);
    step();
    drive_resp(5'd1, 12'hFFF);
    exp_q.push_back(12'h7FF);
    step();
    response_valid = 1'b0;
    chk("ovr_first_valid", {31'd0, sample_valid}, 32'd1);
    chk("ovr_first_data", {20'd0, sample_data}, {20'd0, exp_q.pop_front()});
    chk("ovr_first_count", {16'd0, overrun_count}, 32'd0);
    wait_cmd(40, n);
    step();
    drive_resp(5'd1, 12'h000);
    exp_q.push_back(12'h800);
    step();
    response_valid = 1'b0;
    enable = 1'b0;
    chk("ovr_count", {16'd0, overrun_count}, 32'd1);
    chk("ovr_data", {20'd0, sample_data}, {20'd0, exp_q.pop_front()});
    repeat (3) step();
    chk("ovr_valid_held", {31'd0, sample_valid}, 32'd1);
    chk("ovr_data_held", {20'd0, sample_data}, 32'h800);
    sample_ready = 1'b1;
    step();
    chk("ovr_drain", {31'd0, sample_valid}, 32'd0);
    chk("ovr_error_unchanged", {16'd0, error_count}, 32'd1);

    // Dropped tick: 1st tick issues, 2nd goes pending, 3rd is dropped at edge 48
    command_ready = 1'b0; enable = 1'b1;
    n = 0;
    while (error_count == 16'd1 && n < 80) begin
      step();
      n++;
    end
    chk("drop_edge", n, 32'd48);
    chk("drop_error", {16'd0, error_count}, 32'd2);
    chk("drop_still_issue", {31'd0, command_valid}, 32'd1);

    // Reset mid-ISSUE
    rst = 1'b1;
    step();
    chk("mrst_cmd_valid", {31'd0, command_valid}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_error", {16'd0, error_count}, 32'd0);
    chk("mrst_overrun", {16'd0, overrun_count}, 32'd0);
    chk("mrst_sample_valid", {31'd0, sample_valid}, 32'd0);
    rst = 1'b0; enable = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
